// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states and requester ids.
// Optional round-robin arbitration is enabled with the MEM_ARB_RR_EN macro.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } arb_state_e;

    localparam logic REQ_F = 1'b0;
    localparam logic REQ_D = 1'b1;

    // One-hot per-port strobe vector: bit 1 = D, bit 0 = F.
    function automatic logic [1:0] id_vec(input logic id);
        return {(id == REQ_D), (id == REQ_F)};
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch (F) and load/store (D) ports.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise D has fixed priority.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic f_req,
    input  logic d_req,
    input  logic last_gnt,
    output logic any_req,
    output logic win_id
);

`ifndef MEM_ARB_RR_EN
    logic unused_last_gnt_s;
    assign unused_last_gnt_s = last_gnt;
`endif

    // Winner selection; a lone requester always wins.
    always_comb begin
        any_req = f_req | d_req;
        win_id  = REQ_F;
`ifdef MEM_ARB_RR_EN
        if (f_req && d_req) begin
            win_id = (last_gnt == REQ_D) ? REQ_F : REQ_D;
        end else if (d_req) begin
            win_id = REQ_D;
        end else begin
            win_id = REQ_F;
        end
`else
        if (d_req) begin
            win_id = REQ_D;
        end else begin
            win_id = REQ_F;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch (F) and load/store (D).
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed D-over-F priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_valid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    arb_state_e        state_r, state_n;
    logic [CNT_W-1:0]  cnt_r, cnt_n;
    logic              id_r, id_n;
    logic              we_r, we_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;
    logic [1:0]        gnt_n;
    logic [1:0]        valid_n;
    logic              rd_n, wr_n;
    logic [DATA_W-1:0] f_rdata_n, d_rdata_n;
    logic              any_req_s, win_id_s, last_gnt_s;

`ifdef MEM_ARB_RR_EN
    logic last_gnt_r;

    // Remember which port was granted most recently; resets to D so F wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_r <= REQ_D;
        end else if (state_r == ST_ISSUE) begin
            last_gnt_r <= id_r;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

    assign last_gnt_s = last_gnt_r;
`else
    assign last_gnt_s = REQ_D;
`endif

    mem_arb_pick u_pick (
        .f_req    (f_req),
        .d_req    (d_req),
        .last_gnt (last_gnt_s),
        .any_req  (any_req_s),
        .win_id   (win_id_s)
    );

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        id_n      = id_r;
        we_n      = we_r;
        addr_n    = mem_addr;
        wdata_n   = mem_wdata;
        gnt_n     = 2'b00;
        valid_n   = 2'b00;
        rd_n      = 1'b0;
        wr_n      = 1'b0;
        f_rdata_n = {DATA_W{1'b0}};
        d_rdata_n = {DATA_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_n = ST_ISSUE;
                    id_n    = win_id_s;
                    if (win_id_s == REQ_D) begin
                        we_n    = d_we;
                        addr_n  = d_addr;
                        wdata_n = d_wdata;
                    end else begin
                        we_n    = 1'b0;
                        addr_n  = f_addr;
                        wdata_n = {DATA_W{1'b0}};
                    end
                    gnt_n = id_vec(win_id_s);
                    rd_n  = ~we_n;
                    wr_n  = we_n;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_n   = CNT_W'(MEM_LAT);
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_n = cnt_r - CNT_W'(1);
                // Last wait cycle: capture the read word (writes complete with zero).
                if (cnt_r == CNT_W'(1)) begin
                    state_n = ST_RESP;
                    valid_n = id_vec(id_r);
                    if (!we_r && (id_r == REQ_D)) begin
                        d_rdata_n = mem_rdata;
                    end else if (!we_r) begin
                        f_rdata_n = mem_rdata;
                    end else begin
                        d_rdata_n = {DATA_W{1'b0}};
                    end
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, capture and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            id_r      <= REQ_F;
            we_r      <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
            f_gnt     <= 1'b0;
            d_gnt     <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            f_valid   <= 1'b0;
            d_valid   <= 1'b0;
            f_rdata   <= {DATA_W{1'b0}};
            d_rdata   <= {DATA_W{1'b0}};
            busy      <= 1'b0;
        end else begin
            state_r   <= state_n;
            cnt_r     <= cnt_n;
            id_r      <= id_n;
            we_r      <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            f_gnt     <= gnt_n[0];
            d_gnt     <= gnt_n[1];
            mem_read  <= rd_n;
            mem_write <= wr_n;
            f_valid   <= valid_n[0];
            d_valid   <= valid_n[1];
            f_rdata   <= f_rdata_n;
            d_rdata   <= d_rdata_n;
            busy      <= (state_n != ST_IDLE);
        end
    end

endmodule
